dendrite: RTL and testbench

Input-side companion to the soma: receives spike events arriving from upstream axons, buffers them, looks up each event's synaptic weight, and delivers one (weight, spike-time) pair per cycle to the soma's `weight`/`in_spike` inputs. Delivery stalls while the soma is refractory. A killed neuron absorbs and counts incoming events instead of back-pressuring the network.

---
 rtl/dendrite.sv | 186 ++++++++++++++++++
 tb/tb_dendrite.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dendrite.sv
// rtl/dendrite.sv - spike event buffer with synaptic weight lookup feeding the soma
//
// Purpose:
//   Accepts spike events {src, time} from upstream axons into a small FIFO,
//   looks up the synaptic weight of each event's source when it leaves the
//   FIFO, and presents one (weight, time) pair per cycle to the soma. Delivery
//   holds while the soma is refractory. A killed neuron flushes its FIFO and
//   absorbs new events, counting everything discarded in a saturating counter.
//
// Ports:
//   clk         clock, all state on rising edge
//   rst         synchronous reset, active low
//   kill        neuron deactivated (level)
//   wr_en       weight write strobe
//   wr_addr     synapse index to write (out-of-range writes ignored)
//   wr_weight   weight value to write
//   spk_valid   upstream event valid
//   spk_src     presynaptic source index of the event
//   spk_time    inter-spike time carried with the event
//   spk_ready   event accepted when high together with spk_valid
//   soma_busy   soma refractory, hold delivery
//   out_valid   one-cycle pulse per delivered event
//   out_weight  weight of the delivered event
//   out_spike   time of the delivered event
//   fifo_level  current FIFO occupancy
//   drop_cnt    saturating count of discarded events

module dendrite #(
    parameter int DEPTH = 4,
    parameter int N_SYN = 8,
    parameter int SRC_W = $clog2(N_SYN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    kill,
    input  logic                    wr_en,
    input  logic [SRC_W-1:0]        wr_addr,
    input  logic [7:0]              wr_weight,
    input  logic                    spk_valid,
    input  logic [SRC_W-1:0]        spk_src,
    input  logic [7:0]              spk_time,
    output logic                    spk_ready,
    input  logic                    soma_busy,
    output logic                    out_valid,
    output logic [7:0]              out_weight,
    output logic [7:0]              out_spike,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [7:0]              drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Weight file
    logic [7:0]       weight_q [N_SYN];
    logic [7:0]       weight_d [N_SYN];

    // FIFO storage and control
    logic [SRC_W-1:0] fifo_src_q  [DEPTH];
    logic [7:0]       fifo_time_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;

    // Output registers
    logic             out_valid_q,  out_valid_d;
    logic [7:0]       out_weight_q, out_weight_d;
    logic [7:0]       out_spike_q,  out_spike_d;
    logic [7:0]       drop_q,       drop_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             wr_in_range;
    logic             head_in_range;
    logic [SRC_W-1:0] head_src;
    logic [7:0]       head_time;
    logic [7:0]       head_weight;
    logic [8:0]       drop_sum;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);

    // Ready comes only from registered state: a full FIFO never accepts,
    // even if a pop happens on the same edge. While killed every event is
    // absorbed. During reset nothing is accepted.
    always_comb begin
        spk_ready = 1'b0;
        if (rst) begin
            spk_ready = kill ? 1'b1 : !full;
        end
    end

    assign push = spk_valid && spk_ready && !kill;
    assign pop  = !empty && !soma_busy && !kill;

    assign head_src  = fifo_src_q[rd_ptr_q];
    assign head_time = fifo_time_q[rd_ptr_q];

    // Source indices beyond the weight file are legal events with weight 0.
    assign head_in_range = ({1'b0, head_src} < (SRC_W+1)'(N_SYN));
    assign wr_in_range   = ({1'b0, wr_addr}  < (SRC_W+1)'(N_SYN));
    assign head_weight   = head_in_range ? weight_q[head_src] : 8'h00;

    // Everything discarded on a kill edge: all queued entries plus any
    // event presented that cycle (spk_ready is 1 while killed).
    assign drop_sum = {1'b0, drop_q} + 9'(level_q) + 9'(spk_valid);

    always_comb begin
        weight_d = weight_q;
        if (wr_en && wr_in_range) begin
            weight_d[wr_addr] = wr_weight;
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        out_valid_d  = 1'b0;
        out_weight_d = out_weight_q;
        out_spike_d  = out_spike_q;
        drop_d       = drop_q;

        if (kill) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d     = rd_ptr_q + PTR_W'(1);
                out_valid_d  = 1'b1;
                // weight_q is the pre-edge value, so a same-edge write to
                // this synapse only affects later events.
                out_weight_d = head_weight;
                out_spike_d  = head_time;
            end
            level_d = level_q + LVL_W'(push) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_SYN; i++) begin
                weight_q[i] <= 8'h00;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            out_valid_q  <= 1'b0;
            out_weight_q <= 8'h00;
            out_spike_q  <= 8'h00;
            drop_q       <= 8'h00;
        end else begin
            weight_q     <= weight_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            out_valid_q  <= out_valid_d;
            out_weight_q <= out_weight_d;
            out_spike_q  <= out_spike_d;
            drop_q       <= drop_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by the pointers.
    // push is already blocked during reset because spk_ready is low.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_src_q[wr_ptr_q]  <= spk_src;
            fifo_time_q[wr_ptr_q] <= spk_time;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_weight = out_weight_q;
    assign out_spike  = out_spike_q;
    assign fifo_level = level_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_dendrite.sv
// tb/tb_dendrite.sv - directed scoreboard bench for dendrite

module tb_dendrite;

    localparam int DEPTH = 4;
    localparam int N_SYN = 6;
    localparam int SRC_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             kill;
    logic             wr_en;
    logic [SRC_W-1:0] wr_addr;
    logic [7:0]       wr_weight;
    logic             spk_valid;
    logic [SRC_W-1:0] spk_src;
    logic [7:0]       spk_time;
    logic             spk_ready;
    logic             soma_busy;
    logic             out_valid;
    logic [7:0]       out_weight;
    logic [7:0]       out_spike;
    logic [2:0]       fifo_level;
    logic [7:0]       drop_cnt;

    always #5 clk = ~clk;

    dendrite #(.DEPTH(DEPTH), .N_SYN(N_SYN), .SRC_W(SRC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .kill       (kill),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_weight  (wr_weight),
        .spk_valid  (spk_valid),
        .spk_src    (spk_src),
        .spk_time   (spk_time),
        .spk_ready  (spk_ready),
        .soma_busy  (soma_busy),
        .out_valid  (out_valid),
        .out_weight (out_weight),
        .out_spike  (out_spike),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt)
    );

    int          errors = 0;
    int          checks = 0;
    int          pulses = 0;
    logic [15:0] sb_q[$];
    logic [7:0]  mw [N_SYN];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: check any delivered event against the scoreboard, model the
    // upcoming edge (reset, kill flush, weight write, handshake), then return
    // 1 time unit after the edge so new inputs can be driven.
    task automatic tick();
        logic [15:0] e;
        @(negedge clk);
        if (out_valid) begin
            pulses++;
            chk("sb_has_entry_for_pulse", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("out_weight", 32'(out_weight), 32'(e[15:8]));
                chk("out_spike",  32'(out_spike),  32'(e[7:0]));
            end
        end
        if (!rst) begin
            sb_q.delete();
            for (int i = 0; i < N_SYN; i++) mw[i] = 8'h00;
        end else begin
            if (kill) sb_q.delete();
            if (wr_en && (int'(wr_addr) < N_SYN)) mw[wr_addr] = wr_weight;
            if (spk_valid && spk_ready && !kill)
                sb_q.push_back({(int'(spk_src) < N_SYN) ? mw[spk_src] : 8'h00, spk_time});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [7:0] w);
        wr_en = 1'b1; wr_addr = SRC_W'(a); wr_weight = w;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic send(input int s, input logic [7:0] t);
        spk_valid = 1'b1; spk_src = SRC_W'(s); spk_time = t;
        tick();
        spk_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; kill = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_weight = '0;
        spk_valid = 1'b0; spk_src = '0; spk_time = '0; soma_busy = 1'b0;
        for (int i = 0; i < N_SYN; i++) mw[i] = 8'h00;

        // Reset state
        tick(); tick();
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_out_weight", 32'(out_weight), 32'd0);
        chk("rst_out_spike",  32'(out_spike),  32'd0);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("rst_drop_cnt",   32'(drop_cnt),   32'd0);
        chk("rst_spk_ready",  32'(spk_ready),  32'd0);
        rst = 1'b1;
        tick();
        chk("idle_spk_ready", 32'(spk_ready), 32'd1);

        // Single event latency: handshake edge N, out_valid after edge N+1
        wr(3, 8'h25);
        send(3, 8'd7);
        chk("t1_level_after_push", 32'(fifo_level), 32'd1);
        chk("t1_no_early_valid",   32'(out_valid),  32'd0);
        tick();
        chk("t1_valid_after_2_edges", 32'(out_valid), 32'd1);
        chk("t1_level_back_0",        32'(fifo_level), 32'd0);
        tick();
        chk("t1_single_pulse", 32'(out_valid), 32'd0);
        chk("t1_sb_drained",   32'(sb_q.size()), 32'd0);

        // Out-of-range write ignored; out-of-range source delivers weight 0
        wr(7, 8'h77);
        send(7, 8'h3C);
        tick(); tick();
        chk("oor_sb_drained", 32'(sb_q.size()), 32'd0);

        // Stall with soma_busy, fill FIFO, release in arrival order
        wr(1, 8'h11); wr(2, 8'h05); wr(4, 8'h44);
        soma_busy = 1'b1;
        spk_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            spk_src = SRC_W'(i + 1); spk_time = 8'(8'h10 + i);
            chk($sformatf("t2_ready_%0d", i), 32'(spk_ready), (i < 4) ? 32'd1 : 32'd0);
            tick();
        end
        spk_valid = 1'b0;
        chk("t2_level_full", 32'(fifo_level), 32'd4);
        chk("t2_ready_full", 32'(spk_ready),  32'd0);
        soma_busy = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t2_pulse_%0d", i), 32'(out_valid), 32'd1);
        end
        tick();
        chk("t2_pulse_count", 32'(pulses),     32'd4);
        chk("t2_done_valid",  32'(out_valid),  32'd0);
        chk("t2_ready_again", 32'(spk_ready),  32'd1);
        chk("t2_level_empty", 32'(fifo_level), 32'd0);

        // Same-edge weight write and pop of that synapse: old value delivered
        soma_busy = 1'b1;
        send(2, 8'h21);
        soma_busy = 1'b0;
        wr(2, 8'h10);
        chk("t3_pop_with_write", 32'(out_valid), 32'd1);
        send(2, 8'h22);
        tick(); tick();
        chk("t3_sb_drained", 32'(sb_q.size()), 32'd0);

        // Kill flushes 3 queued entries plus the presented event
        soma_busy = 1'b1;
        send(1, 8'h31); send(1, 8'h32); send(1, 8'h33);
        chk("t4_level_3", 32'(fifo_level), 32'd3);
        soma_busy = 1'b0;
        kill = 1'b1; spk_valid = 1'b1; spk_src = 3'd4; spk_time = 8'h34;
        chk("t4_kill_ready", 32'(spk_ready), 32'd1);
        tick();
        kill = 1'b0; spk_valid = 1'b0;
        chk("t4_level_flushed", 32'(fifo_level), 32'd0);
        chk("t4_drop_cnt",      32'(drop_cnt),   32'd4);
        chk("t4_no_valid",      32'(out_valid),  32'd0);
        send(4, 8'h35);
        tick(); tick();
        chk("t4_resume_sb_drained", 32'(sb_q.size()), 32'd0);
        chk("t4_resume_drop_hold",  32'(drop_cnt),    32'd4);

        // Saturation of drop_cnt
        kill = 1'b1; spk_valid = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        chk("t5_drop_104", 32'(drop_cnt), 32'd104);
        for (int i = 0; i < 200; i++) tick();
        chk("t5_drop_sat", 32'(drop_cnt), 32'd255);
        kill = 1'b0; spk_valid = 1'b0;
        tick();

        // Reset mid-burst with entries queued and out_valid high
        soma_busy = 1'b1;
        spk_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            spk_src = 3'd1; spk_time = 8'(8'h50 + i);
            tick();
        end
        soma_busy = 1'b0;
        spk_time = 8'h53;
        tick();
        chk("t6_pre_valid", 32'(out_valid),  32'd1);
        chk("t6_pre_level", 32'(fifo_level), 32'd3);
        rst = 1'b0; wr_en = 1'b1; wr_addr = 3'd1; wr_weight = 8'h99; kill = 1'b1;
        tick();
        wr_en = 1'b0; kill = 1'b0;
        chk("t6_out_valid",  32'(out_valid),  32'd0);
        chk("t6_out_weight", 32'(out_weight), 32'd0);
        chk("t6_out_spike",  32'(out_spike),  32'd0);
        chk("t6_level",      32'(fifo_level), 32'd0);
        chk("t6_drop",       32'(drop_cnt),   32'd0);
        chk("t6_ready_rst",  32'(spk_ready),  32'd0);
        rst = 1'b1;
        spk_valid = 1'b0;
        tick();
        send(1, 8'h60);
        tick();
        chk("t6_weight_cleared_valid", 32'(out_valid),  32'd1);
        chk("t6_weight_cleared",       32'(out_weight), 32'd0);
        tick();
        chk("t6_sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
